// File: rtl/mmcm_reconfig_pkg.sv
// Shared types and DRP register map for the pixel-clock MMCM reconfiguration controller.
package mmcm_reconfig_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_WAIT,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_WR_WAIT,
    S_NEXT,
    S_RELEASE,
    S_LOCK_WAIT
  } state_e;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
  } drp_entry_t;

  localparam logic [6:0] ADDR_CLKOUT0_1  = 7'h08;
  localparam logic [6:0] ADDR_CLKOUT0_2  = 7'h09;
  localparam logic [6:0] ADDR_CLKFBOUT_1 = 7'h14;
  localparam logic [6:0] ADDR_CLKFBOUT_2 = 7'h15;
  localparam logic [6:0] ADDR_DIVCLK     = 7'h16;
  localparam logic [6:0] ADDR_LOCK1      = 7'h18;
  localparam logic [6:0] ADDR_LOCK2      = 7'h19;
  localparam logic [6:0] ADDR_LOCK3      = 7'h1A;
  localparam logic [6:0] ADDR_FILT1      = 7'h4E;
  localparam logic [6:0] ADDR_FILT2      = 7'h4F;

endpackage

// File: rtl/mmcm_reconfig_rom.sv
// Per-mode DRP register table: (mode, idx) -> {addr, keep-mask, data}.
import mmcm_reconfig_pkg::*;

module mmcm_reconfig_rom #(
  parameter int NUM_MODES = 4,
  parameter int NUM_REGS  = 8
) (
  input  logic [$clog2(NUM_MODES)-1:0] mode,
  input  logic [$clog2(NUM_REGS)-1:0]  idx,
  output drp_entry_t                   entry
);

  localparam logic [6:0] ADDR [NUM_REGS] = '{
    ADDR_CLKOUT0_1, ADDR_CLKOUT0_2,
    ADDR_CLKFBOUT_1, ADDR_CLKFBOUT_2,
    ADDR_DIVCLK, ADDR_LOCK1,
    ADDR_FILT1, ADDR_FILT2
  };

  localparam logic [15:0] MASK [NUM_REGS] = '{
    16'h1000, 16'hFC00, 16'h1000, 16'hFC00,
    16'hC000, 16'hFC00, 16'h66FF, 16'h666F
  };

  // Data never overlaps the keep-mask of its register.
  localparam logic [15:0] DATA [NUM_MODES][NUM_REGS] = '{
    '{16'h0145, 16'h0000, 16'h0104, 16'h0000,
      16'h1041, 16'h01E8, 16'h9900, 16'h1100},
    '{16'h0186, 16'h0080, 16'h0145, 16'h0000,
      16'h1041, 16'h03E8, 16'h9800, 16'h8890},
    '{16'h0041, 16'h0000, 16'h0209, 16'h0080,
      16'h1041, 16'h00FA, 16'h8900, 16'h9090},
    '{16'h0082, 16'h0000, 16'h0271, 16'h0040,
      16'h0041, 16'h0113, 16'h1100, 16'h9900}
  };

  always_comb begin
    entry      = '0;
    entry.addr = ADDR[idx];
    entry.mask = MASK[idx];
    entry.data = DATA[mode][idx];
  end

endmodule

// File: rtl/mmcm_reconfig_ctrl.sv
// MMCM DRP reconfiguration FSM: hold RST, read-modify-write the mode table, wait LOCKED.
// Define STARTUP_LOAD_EN to self-load mode 0 after every reset.
import mmcm_reconfig_pkg::*;

module mmcm_reconfig_ctrl #(
  parameter int NUM_MODES    = 4,
  parameter int NUM_REGS     = 8,
  parameter int RST_HOLD     = 16,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic [$clog2(NUM_MODES)-1:0] mode_sel,
  input  logic                         mode_req,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [$clog2(NUM_MODES)-1:0] cur_mode,
  output logic                         mmcm_rst,
  output logic [6:0]                   daddr,
  output logic [15:0]                  di,
  output logic                         den,
  output logic                         dwe,
  input  logic [15:0]                  drp_do,
  input  logic                         drdy,
  input  logic                         locked
);

  localparam int MW = $clog2(NUM_MODES);
  localparam int IW = $clog2(NUM_REGS);
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  state_e         state_q, state_d;
  logic [MW-1:0]  mode_q, mode_d;
  logic [MW-1:0]  cur_mode_q, cur_mode_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [15:0]    rdata_q, rdata_d;
  logic [15:0]    di_q, di_d;
  logic [6:0]     daddr_q, daddr_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           error_q, error_d;
  logic           rst_q, rst_d;
  logic           den_q, den_d;
  logic           dwe_q, dwe_d;
  drp_entry_t     entry;

`ifdef STARTUP_LOAD_EN
  logic start_q;
  logic start_d;
  assign start_d = start_q && (state_q != S_IDLE);
  always_ff @(posedge clk_in) begin
    if (reset) start_q <= 1'b1;
    else       start_q <= start_d;
  end
`else
  logic start_q;
  assign start_q = 1'b0;
`endif

  mmcm_reconfig_rom #(
    .NUM_MODES(NUM_MODES),
    .NUM_REGS (NUM_REGS)
  ) u_rom (
    .mode (mode_q),
    .idx  (idx_q),
    .entry(entry)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cur_mode_d = cur_mode_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    di_d       = di_q;
    daddr_d    = daddr_q;
    busy_d     = busy_q;
    error_d    = error_q;
    rst_d      = rst_q;
    done_d     = 1'b0;
    den_d      = 1'b0;
    dwe_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // done_q high means the request collided with completion
        if (start_q || (mode_req && !done_q)) begin
          mode_d  = start_q ? '0 : mode_sel;
          idx_d   = '0;
          cnt_d   = '0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          rst_d   = 1'b1;
          state_d = S_RST_WAIT;
        end
      end
      S_RST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(RST_HOLD - 1)) state_d = S_RD;
      end
      S_RD: begin
        den_d   = 1'b1;
        daddr_d = entry.addr;
        cnt_d   = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (drdy && !den_q) begin
          rdata_d = drp_do;
          state_d = S_WR;
        end else if (cnt_q == CW'(DRDY_TIMEOUT - 1)) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          rst_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        den_d   = 1'b1;
        dwe_d   = 1'b1;
        daddr_d = entry.addr;
        di_d    = (rdata_q & entry.mask) | entry.data;
        cnt_d   = '0;
        state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (drdy && !den_q) begin
          state_d = S_NEXT;
        end else if (cnt_q == CW'(DRDY_TIMEOUT - 1)) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          rst_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_NEXT: begin
        if (idx_q == IW'(NUM_REGS - 1)) begin
          state_d = S_RELEASE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_RD;
        end
      end
      S_RELEASE: begin
        rst_d   = 1'b0;
        cnt_d   = '0;
        state_d = S_LOCK_WAIT;
      end
      S_LOCK_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // early LOCKED may still be the pre-reset value
        if (locked && cnt_q >= CW'(2)) begin
          done_d     = 1'b1;
          busy_d     = 1'b0;
          cur_mode_d = mode_q;
          state_d    = S_IDLE;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      cur_mode_q <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      di_q       <= '0;
      daddr_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      rst_q      <= 1'b0;
      den_q      <= 1'b0;
      dwe_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cur_mode_q <= cur_mode_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      di_q       <= di_d;
      daddr_q    <= daddr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      rst_q      <= rst_d;
      den_q      <= den_d;
      dwe_q      <= dwe_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign cur_mode = cur_mode_q;
  assign mmcm_rst = rst_q;
  assign daddr    = daddr_q;
  assign di       = di_q;
  assign den      = den_q;
  assign dwe      = dwe_q;

endmodule

// File: tb/tb_mmcm_reconfig_ctrl.sv
// Scoreboard bench for mmcm_reconfig_ctrl with a DRP RAM model and a LOCKED model.
module tb_mmcm_reconfig_ctrl;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode_sel = '0;
  logic        mode_req = 1'b0;
  logic [15:0] drp_do = '0;
  logic        drdy = 1'b0;
  logic        locked = 1'b0;
  logic        busy, done, error, mmcm_rst, den, dwe;
  logic [1:0]  cur_mode;
  logic [6:0]  daddr;
  logic [15:0] di;

  mmcm_reconfig_ctrl dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .mode_sel(mode_sel),
    .mode_req(mode_req),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .cur_mode(cur_mode),
    .mmcm_rst(mmcm_rst),
    .daddr   (daddr),
    .di      (di),
    .den     (den),
    .dwe     (dwe),
    .drp_do  (drp_do),
    .drdy    (drdy),
    .locked  (locked)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit          we;
    logic [6:0]  a;
    logic [15:0] d;
  } drp_t;

  typedef struct {
    bit         dn;
    bit         er;
    logic [1:0] m;
  } end_t;

  drp_t drp_q[$];
  end_t end_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] ram [128];
  logic [15:0] rd_data = '0;
  bit no_drdy = 0;
  bit hold_unlock = 0;
  int pend = 0;
  int lcnt = 0;
  int overlap = 0;
  int dwe_bad = 0;
  int done_wide = 0;
  bit busy_p = 0;
  bit done_p = 0;
  bit rst_p = 0;
  int t_den = 0;
  int t_rst_fall = 0;
  int t_busy_fall = 0;

  localparam logic [6:0] A [8] = '{
    7'h08, 7'h09, 7'h14, 7'h15, 7'h16, 7'h18, 7'h4E, 7'h4F};
  // Mode 2 over RAM preloaded 0xFFFF: (0xFFFF & mask) | data
  localparam logic [15:0] W_M2_FF [8] = '{
    16'h1041, 16'hFC00, 16'h1209, 16'hFC80,
    16'hD041, 16'hFCFA, 16'hEFFF, 16'hF6FF};
  localparam logic [15:0] W_M1_00 [8] = '{
    16'h0186, 16'h0080, 16'h0145, 16'h0000,
    16'h1041, 16'h03E8, 16'h9800, 16'h8890};
  localparam logic [15:0] W_M3_FF [8] = '{
    16'h1082, 16'hFC00, 16'h1271, 16'hFC40,
    16'hC041, 16'hFD13, 16'h77FF, 16'hFF6F};
`ifdef STARTUP_LOAD_EN
  localparam logic [15:0] W_M0_00 [8] = '{
    16'h0145, 16'h0000, 16'h0104, 16'h0000,
    16'h1041, 16'h01E8, 16'h9900, 16'h1100};
`endif

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk_in) cyc++;

  // DRP RAM model (drdy 3 cycles after den) and LOCKED model (200 cycles after rst falls)
  always @(negedge clk_in) begin
    drdy = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0 && !no_drdy) begin
        drdy = 1'b1;
        drp_do = rd_data;
      end
    end
    if (den) begin
      if (pend > 0) overlap++;
      pend = 3;
      if (dwe) ram[daddr] = di;
      rd_data = ram[daddr];
    end
    if (mmcm_rst) begin
      locked = 1'b0;
      lcnt = 0;
    end else if (lcnt < 200) begin
      lcnt++;
    end else if (!hold_unlock) begin
      locked = 1'b1;
    end
  end

  // Monitor: pops expected DRP accesses and completions
  always @(negedge clk_in) begin
    drp_t e;
    end_t c;
    if (den) begin
      t_den = cyc;
      if (drp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_drp: addr 0x%0h we %0d, want no access", daddr, dwe);
      end else begin
        e = drp_q.pop_front();
        chk("drp_we", 32'(dwe), 32'(e.we));
        chk("drp_addr", 32'(daddr), 32'(e.a));
        if (e.we) chk("drp_di", 32'(di), 32'(e.d));
      end
    end
    if (dwe && !den) dwe_bad++;
    if (done && done_p) done_wide++;
    if (rst_p && !mmcm_rst) t_rst_fall = cyc;
    if (busy_p && !busy) begin
      t_busy_fall = cyc;
      if (end_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_end: busy fell, want no completion");
      end else begin
        c = end_q.pop_front();
        chk("end_done", 32'(done), 32'(c.dn));
        chk("end_error", 32'(error), 32'(c.er));
        chk("end_cur_mode", 32'(cur_mode), 32'(c.m));
        chk("end_mmcm_rst", 32'(mmcm_rst), 32'(0));
      end
    end
    busy_p = busy;
    done_p = done;
    rst_p = mmcm_rst;
  end

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 128; i++) ram[i] = v;
  endtask

  task automatic push_acc(input bit we, input logic [6:0] a,
                          input logic [15:0] d);
    drp_t e;
    e.we = we;
    e.a = a;
    e.d = d;
    drp_q.push_back(e);
  endtask

  task automatic push_seq(input logic [15:0] w [8]);
    for (int i = 0; i < 8; i++) begin
      push_acc(1'b0, A[i], 16'h0);
      push_acc(1'b1, A[i], w[i]);
    end
  endtask

  task automatic push_end(input bit dn, input bit er, input logic [1:0] m);
    end_t c;
    c.dn = dn;
    c.er = er;
    c.m = m;
    end_q.push_back(c);
  endtask

  task automatic req(input logic [1:0] m);
    @(negedge clk_in);
    mode_sel = m;
    mode_req = 1'b1;
    @(negedge clk_in);
    mode_req = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, want 0", nm, budget);
    end
    @(negedge clk_in);
  endtask

  function automatic logic [31:0] outs();
    return {1'b0, busy, done, error, mmcm_rst, den, dwe, cur_mode, daddr, di};
  endfunction

  initial begin
    int n;
    fill(16'h0000);
    mode_sel = 2'd2;
    mode_req = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("reset_outputs_zero", outs(), 32'h0);
    reset = 1'b0;
    mode_req = 1'b0;
`ifdef STARTUP_LOAD_EN
    push_seq(W_M0_00);
    push_end(1'b1, 1'b0, 2'd0);
    @(negedge clk_in);
    chk("startup_busy", 32'(busy), 32'(1));
    wait_idle("startup", 3000);
    chk("startup_cur_mode", 32'(cur_mode), 32'(0));
`else
    repeat (2) @(negedge clk_in);
    chk("req_with_reset_ignored", 32'(busy), 32'(0));
`endif

    // mode 2 with ignored requests while busy
    fill(16'hFFFF);
    push_seq(W_M2_FF);
    push_end(1'b1, 1'b0, 2'd2);
    req(2'd2);
    chk("busy_after_req", 32'(busy), 32'(1));
    chk("rst_after_req", 32'(mmcm_rst), 32'(1));
    for (int k = 0; k < 3; k++) begin
      repeat (30) @(negedge clk_in);
      mode_sel = 2'd3;
      mode_req = 1'b1;
      @(negedge clk_in);
      mode_req = 1'b0;
    end
    wait_idle("mode2", 3000);
    for (int i = 0; i < 8; i++)
      chk("ram_mode2", 32'(ram[A[i]]), 32'(W_M2_FF[i]));
    chk("cur_mode_2", 32'(cur_mode), 32'(2));
    chk("done_one_cycle", 32'(done), 32'(0));

    // mode 1; request placed in the done cycle must be dropped
    fill(16'h0000);
    push_seq(W_M1_00);
    push_end(1'b1, 1'b0, 2'd1);
    req(2'd1);
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    chk("done_seen_mode1", 32'(done), 32'(1));
    mode_sel = 2'd0;
    mode_req = 1'b1;
    @(negedge clk_in);
    mode_req = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("req_at_done_ignored", 32'(busy), 32'(0));
    chk("cur_mode_1", 32'(cur_mode), 32'(1));

    // drdy never returns
    no_drdy = 1;
    fill(16'hFFFF);
    push_acc(1'b0, A[0], 16'h0);
    push_end(1'b0, 1'b1, 2'd1);
    req(2'd3);
    wait_idle("no_drdy", 500);
    chk("drdy_timeout_cycles", 32'(t_busy_fall - t_den), 32'(64));
    chk("error_sticky", 32'(error), 32'(1));
    no_drdy = 0;

    // locked never rises
    hold_unlock = 1;
    push_seq(W_M2_FF);
    push_end(1'b0, 1'b1, 2'd1);
    req(2'd2);
    chk("error_cleared_on_req", 32'(error), 32'(0));
    wait_idle("lock_to", 70000);
    chk("lock_timeout_cycles", 32'(t_busy_fall - t_rst_fall), 32'(65535));
    hold_unlock = 0;

    // recovery after error
    fill(16'hFFFF);
    push_seq(W_M3_FF);
    push_end(1'b1, 1'b0, 2'd3);
    req(2'd3);
    chk("error_cleared_again", 32'(error), 32'(0));
    wait_idle("mode3", 3000);
    chk("cur_mode_3", 32'(cur_mode), 32'(3));
    chk("ram_mode3_filt1", 32'(ram[7'h4E]), 32'(16'h77FF));

    // reset during WR_WAIT, with a request in the same cycle
    fill(16'h0000);
    push_acc(1'b0, A[0], 16'h0);
    push_acc(1'b1, A[0], W_M1_00[0]);
    push_end(1'b0, 1'b0, 2'd0);
    req(2'd1);
    n = 0;
    while (!(den && dwe) && n < 500) begin
      @(negedge clk_in);
      n++;
    end
    chk("first_write_seen", 32'(dwe), 32'(1));
    reset = 1'b1;
    mode_sel = 2'd2;
    mode_req = 1'b1;
    @(negedge clk_in);
    mode_req = 1'b0;
    chk("mid_reset_outputs_zero", outs(), 32'h0);
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
`ifdef STARTUP_LOAD_EN
    push_seq(W_M0_00);
    push_end(1'b1, 1'b0, 2'd0);
    @(negedge clk_in);
    wait_idle("startup2", 3000);
`else
    repeat (3) @(negedge clk_in);
    chk("idle_after_reset", 32'(busy), 32'(0));
`endif

    chk("drp_queue_empty", 32'(drp_q.size()), 32'(0));
    chk("end_queue_empty", 32'(end_q.size()), 32'(0));
    chk("den_overlap", 32'(overlap), 32'(0));
    chk("dwe_without_den", 32'(dwe_bad), 32'(0));
    chk("done_width", 32'(done_wide), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
